mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Sub-word load/store adapter between the multicycle datapath and the word-only `Memory` block. Accepts one byte, halfword or word request at a time from the datapath, drives `Memory`'s word-addressed port, and performs read-modify-write for `sb`/`sh`. It also sign- or zero-extends loaded data and flags misaligned or unmapped accesses without touching memory.

## Interface
- `TEXT_BASE`, 32'h00400000, first byte of the readable, non-writable text region
- `DATA_BASE`, 32'h10010000, first byte of the readable/writable data region
- `REGION_SIZE`, 32'h1000, size in bytes of each region

Ports:
- `clock` in 1: single clock; the FSM updates on posedge.
- `clear` in 1: asynchronous, active-high reset. Share it with `Memory.clear`.
- `req` in 1: request strobe, sampled in IDLE only
- `we` in 1: 1 = store, 0 = load
- `size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal (fault)
- `sign_ext` in 1: for loads, 1 = sign-extend, 0 = zero-extend; ignored for word loads and stores
- `addr` in 32: byte address
- `wdata` in 32: store data, right-justified
- `rdata` out 32: load result; holds until the next successful load
- `ready` out 1: one-cycle completion pulse
- `fault` out 1: qualifies `ready`; 1 = request rejected
- `busy` out 1: high in every state except IDLE
- `mem_address` out 32: word-aligned address to `Memory`
- `mem_write` out 1: write enable to `Memory`
- `mem_write_data` out 32: write data to `Memory`
- `mem_read_data` in 32: combinational read data from `Memory`

## Operation
- Byte order is little-endian: byte k of a word is bits [8k+7:8k], with k = addr[1:0].
- **Request checks in IDLE.** On `req` the block latches `addr`, `we`, `size`, `sign_ext` and `wdata`. It then checks:
  - Alignment: a halfword needs addr[0]=0; a word needs addr[1:0]=0.
  - Mapping: the address must fall in [base, base+REGION_SIZE) of either region.
  - Write permission: a store to the text region faults.
  - `size`: a value of 11 faults.
- **State routing out of IDLE:**
  - Any check fails → FAULT.
  - Word store → WRITE.
  - Any load or sub-word store → READ.
- **READ.** Drive `mem_address` = {addr[31:2],2'b00} with `mem_write`=0.
  - Load: at the next posedge, register the extracted and extended lane into `rdata`, then go to DONE.
  - Sub-word store: at the next posedge, register `mem_read_data` into the merge buffer, replacing only the target byte/halfword lane with wdata[7:0] or wdata[15:0], then go to WRITE.
- **WRITE.** Drive `mem_write`=1, the same word address, and `mem_write_data` = merged word (word store: `wdata`). Then go to DONE. `Memory` commits on the negedge inside this cycle.
- **DONE.** `ready`=1, `fault`=0 for one cycle, then return to IDLE.
- **FAULT.** `ready`=1, `fault`=1 for one cycle, then return to IDLE. Memory is not written and `rdata` is unchanged.
- `req` is ignored while `busy`=1. A new request may be sampled in the cycle after DONE/FAULT.
- Stores never modify `rdata`.
- `mem_write` is decoded from the state. All other memory-side outputs come from registers, so they are stable across the write negedge.

## Timing
- Reset values: state IDLE, `rdata`=0, `ready`=0, `fault`=0, `busy`=0, `mem_address`=0, `mem_write`=0, `mem_write_data`=0, merge buffer 0.
- Latency, counted from the posedge that samples `req` to the `ready` cycle:
  - Fault: 1 cycle.
  - Load: 2 cycles (READ, DONE).
  - Word store: 2 cycles (WRITE, DONE).
  - Sub-word store: 3 cycles (READ, WRITE, DONE).
- `mem_write` is high for exactly one cycle per store and never for faults or loads.
- `clear` asserted in any state returns the block to IDLE immediately with reset output values. A store in flight is abandoned; since `Memory` clears on the same signal, no partial write survives.
- `req` held high continuously: after each DONE/FAULT the request is re-sampled, which yields back-to-back transactions with one IDLE cycle between them.

## Test plan
- Word load at 0x10010000 after clear → `ready` two cycles after the request, `rdata`=0x00000064, `fault`=0.
- Byte loads at 0x10010004: with `sign_ext`=1 → `rdata`=0xFFFFFFC8; with `sign_ext`=0 → `rdata`=0x000000C8.
- `sb` at 0x10010001 with `wdata`=0x000000AB → exactly one `mem_write` pulse, 3-cycle latency; a following `lw` at 0x10010000 returns 0x0000AB64.
- `sh` at 0x10010003 and `lw` at 0x10010002 → `ready`=`fault`=1 after one cycle, no `mem_write`, `rdata` unchanged.
- `sw` at 0x00400000 and `lw` at 0x20000000 → both fault; a following `lw` at 0x00400000 returns 0x00221820.
- `clear` pulsed during the WRITE of an `sh` → outputs return to reset values, `busy`=0; a subsequent `lw` at 0x10010000 returns 0x00000064.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Request/response bundle between the datapath, mem_access_unit and the word-only Memory.
// The slave modport is the adapter's view; the master modport is the datapath plus Memory side.
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        fault;
  logic        busy;
  logic [31:0] mem_address;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport slave (
    input  req, we, size, sign_ext, addr, wdata, mem_read_data,
    output rdata, ready, fault, busy, mem_address, mem_write, mem_write_data
  );

  modport master (
    output req, we, size, sign_ext, addr, wdata, mem_read_data,
    input  rdata, ready, fault, busy, mem_address, mem_write, mem_write_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/halfword/word load-store adapter in front of a word-addressed Memory.
// Sub-word stores use read-modify-write; loads are lane-extracted and sign/zero-extended.
module mem_access_unit #(
  parameter logic [31:0] TEXT_BASE   = 32'h0040_0000,
  parameter logic [31:0] DATA_BASE   = 32'h1001_0000,
  parameter logic [31:0] REGION_SIZE = 32'h0000_1000
) (
  input  logic            clock,
  input  logic            clear,
  mem_access_unit_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_DONE, S_FAULT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] mem_address_q, mem_address_d;

  logic        in_text, in_data, misaligned, req_fault;
  logic [31:0] shifted, load_val, merged;

  assign in_text    = (bus.addr >= TEXT_BASE) && (bus.addr < TEXT_BASE + REGION_SIZE);
  assign in_data    = (bus.addr >= DATA_BASE) && (bus.addr < DATA_BASE + REGION_SIZE);
  assign misaligned = ((bus.size == 2'b01) && bus.addr[0]) ||
                      ((bus.size == 2'b10) && (bus.addr[1:0] != 2'b00));
  assign req_fault  = (bus.size == 2'b11) || misaligned || !(in_text || in_data) ||
                      (bus.we && in_text);

  // Target lane moved down to bit 0 so extension is lane-independent.
  assign shifted = bus.mem_read_data >> {addr_lo_q, 3'b000};

  always_comb begin
    load_val = bus.mem_read_data;
    case (size_q)
      2'b00:   load_val = sext_q ? {{24{shifted[7]}}, shifted[7:0]} : {24'h0, shifted[7:0]};
      2'b01:   load_val = sext_q ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]};
      default: load_val = bus.mem_read_data;
    endcase
  end

  always_comb begin
    merged = bus.mem_read_data;
    if (size_q == 2'b00) merged[{addr_lo_q, 3'b000} +: 8] = wdata_q[7:0];
    else                 merged[{addr_lo_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q       <= S_IDLE;
      addr_lo_q     <= 2'b00;
      we_q          <= 1'b0;
      size_q        <= 2'b00;
      sext_q        <= 1'b0;
      wdata_q       <= 16'h0;
      rdata_q       <= 32'h0;
      merge_q       <= 32'h0;
      mem_address_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      addr_lo_q     <= addr_lo_d;
      we_q          <= we_d;
      size_q        <= size_d;
      sext_q        <= sext_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      merge_q       <= merge_d;
      mem_address_q <= mem_address_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_lo_d     = addr_lo_q;
    we_d          = we_q;
    size_d        = size_q;
    sext_d        = sext_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    merge_d       = merge_q;
    mem_address_d = mem_address_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          addr_lo_d = bus.addr[1:0];
          we_d      = bus.we;
          size_d    = bus.size;
          sext_d    = bus.sign_ext;
          wdata_d   = bus.wdata[15:0];
          if (req_fault) begin
            state_d = S_FAULT;
          end else begin
            mem_address_d = {bus.addr[31:2], 2'b00};
            if (bus.we && (bus.size == 2'b10)) begin
              merge_d = bus.wdata;
              state_d = S_WRITE;
            end else begin
              state_d = S_READ;
            end
          end
        end
      end
      S_READ: begin
        if (we_q) begin
          merge_d = merged;
          state_d = S_WRITE;
        end else begin
          rdata_d = load_val;
          state_d = S_DONE;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.rdata          = rdata_q;
  assign bus.ready          = (state_q == S_DONE) || (state_q == S_FAULT);
  assign bus.fault          = (state_q == S_FAULT);
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.mem_write      = (state_q == S_WRITE);
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_write_data = merge_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-level reference memory, queued expectations,
// and a monitor that checks every ready pulse; includes a simple word Memory stand-in.
module tb_mem_access_unit;
  localparam logic [31:0] TBASE = 32'h0040_0000;
  localparam logic [31:0] DBASE = 32'h1001_0000;
  localparam logic [31:0] RSIZE = 32'h0000_1000;

  logic clock = 1'b0;
  logic clear = 1'b0;
  mem_access_unit_if bus();

  mem_access_unit dut (.clock(clock), .clear(clear), .bus(bus));

  initial forever #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
    int          lat;
    int          writes;
    int          issue;
    logic [31:0] addr;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int txn = 0;

  function automatic logic [31:0] img(input bit text, input int i);
    if (text) return (i == 0) ? 32'h0022_1820 : (i * 32'h0123_4567) ^ 32'hA5A5_A5A5;
    if (i == 0) return 32'h0000_0064;
    if (i == 1) return 32'h0000_00C8;
    return i * 32'h9E37_79B1;
  endfunction

  // Memory stand-in: combinational read, negedge write, reloads its image on clear.
  logic [31:0] text_mem [0:1023];
  logic [31:0] data_mem [0:1023];

  always @(negedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 1024; i++) begin
        text_mem[i] <= img(1'b1, i);
        data_mem[i] <= img(1'b0, i);
      end
    end else if (bus.mem_write) begin
      if (bus.mem_address >= DBASE && bus.mem_address < DBASE + RSIZE)
        data_mem[bus.mem_address[11:2]] <= bus.mem_write_data;
      else if (bus.mem_address >= TBASE && bus.mem_address < TBASE + RSIZE)
        text_mem[bus.mem_address[11:2]] <= bus.mem_write_data;
    end
  end

  always_comb begin
    bus.mem_read_data = 32'h0;
    if (bus.mem_address >= DBASE && bus.mem_address < DBASE + RSIZE)
      bus.mem_read_data = data_mem[bus.mem_address[11:2]];
    else if (bus.mem_address >= TBASE && bus.mem_address < TBASE + RSIZE)
      bus.mem_read_data = text_mem[bus.mem_address[11:2]];
  end

  // Reference model: a flat byte map plus the last successfully loaded value.
  logic [7:0]  ref_bytes [logic [31:0]];
  logic [31:0] ref_rdata;

  task automatic ref_reset();
    logic [31:0] w;
    ref_bytes.delete();
    for (int i = 0; i < 1024; i++) begin
      w = img(1'b1, i);
      for (int b = 0; b < 4; b++) ref_bytes[TBASE + 4*i + b] = w[8*b +: 8];
      w = img(1'b0, i);
      for (int b = 0; b < 4; b++) ref_bytes[DBASE + 4*i + b] = w[8*b +: 8];
    end
    ref_rdata = 32'h0;
  endtask

  function automatic logic [7:0] rb(input logic [31:0] a);
    return ref_bytes.exists(a) ? ref_bytes[a] : 8'h00;
  endfunction

  function automatic bit in_txt(input logic [31:0] a);
    return a >= TBASE && a < TBASE + RSIZE;
  endfunction

  function automatic bit in_dat(input logic [31:0] a);
    return a >= DBASE && a < DBASE + RSIZE;
  endfunction

  function automatic bit ref_fault(input logic w, input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    if (a % (32'd1 << sz) != 0) return 1'b1;
    if (!in_txt(a) && !in_dat(a)) return 1'b1;
    return w && in_txt(a);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic se, input logic [31:0] a);
    logic [31:0] v = 32'h0;
    int n = 1 << sz;
    for (int i = 0; i < n; i++) v = v | ({24'h0, rb(a + i)} << (8 * i));
    if (se && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 1);
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < (1 << sz); i++) ref_bytes[a + i] = wd[8*i +: 8];
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every ready pulse retires the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!clear) begin
        if (bus.mem_write) wr_cnt++;
        if (bus.ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_ready", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            txn++;
            $display("txn %0d %s addr=%h fault=%0d rdata=%h lat=%0d writes=%0d",
                     txn, e.name, e.addr, bus.fault, bus.rdata, cyc - e.issue + 1, wr_cnt);
            chk({e.name, "_fault"}, {31'h0, bus.fault}, {31'h0, e.fault});
            chk({e.name, "_rdata"}, bus.rdata, e.rdata);
            chk({e.name, "_latency"}, cyc - e.issue + 1, e.lat);
            chk({e.name, "_writes"}, wr_cnt, e.writes);
          end
          wr_cnt = 0;
        end
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (bus.busy && t < 20);
    if (bus.busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic se,
                       input logic [31:0] a, input logic [31:0] wd, input string nm);
    exp_t e;
    int t = 0;
    wait_idle();
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sign_ext = se;
    bus.addr = a; bus.wdata = wd;
    @(posedge clock);
    #1;
    bus.req = 1'b0;
    e.fault  = ref_fault(w, sz, a);
    e.lat    = e.fault ? 1 : ((w && sz != 2'd2) ? 3 : 2);
    e.writes = (w && !e.fault) ? 1 : 0;
    if (!e.fault) begin
      if (w) ref_store(sz, a, wd);
      else   ref_rdata = ref_load(sz, se, a);
    end
    e.rdata = ref_rdata;
    e.issue = cyc;
    e.addr  = a;
    e.name  = nm;
    exp_q.push_back(e);
    do begin
      @(negedge clock);
      t++;
    end while (exp_q.size() != 0 && t < 20);
    if (exp_q.size() != 0) begin
      chk({nm, "_timeout"}, 32'd1, 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    logic [31:0] w;
    int r;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
    bus.addr = 32'h0; bus.wdata = 32'h0;
    ref_reset();
    #2 clear = 1'b1;
    repeat (2) @(negedge clock);
    clear = 1'b0;
    #1;
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_ready", {31'h0, bus.ready}, 32'h0);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_mem_address", bus.mem_address, 32'h0);
    chk("rst_mem_wdata", bus.mem_write_data, 32'h0);

    issue(1'b0, 2'd2, 1'b0, 32'h1001_0000, 32'h0, "lw_data0");
    issue(1'b0, 2'd0, 1'b1, 32'h1001_0004, 32'h0, "lb_c8");
    issue(1'b0, 2'd0, 1'b0, 32'h1001_0004, 32'h0, "lbu_c8");
    issue(1'b1, 2'd0, 1'b0, 32'h1001_0001, 32'h0000_00AB, "sb_ab");
    issue(1'b0, 2'd2, 1'b0, 32'h1001_0000, 32'h0, "lw_after_sb");
    issue(1'b1, 2'd1, 1'b0, 32'h1001_0003, 32'h1234, "sh_misaligned");
    issue(1'b0, 2'd2, 1'b0, 32'h1001_0002, 32'h0, "lw_misaligned");
    issue(1'b1, 2'd2, 1'b0, 32'h0040_0000, 32'hDEAD_BEEF, "sw_text");
    issue(1'b0, 2'd2, 1'b0, 32'h2000_0000, 32'h0, "lw_unmapped");
    issue(1'b0, 2'd2, 1'b0, 32'h0040_0000, 32'h0, "lw_text0");
    issue(1'b0, 2'd2, 1'b0, 32'h1001_0FFC, 32'h0, "lw_data_top");
    issue(1'b0, 2'd0, 1'b0, 32'h1001_1000, 32'h0, "lb_past_data");
    issue(1'b0, 2'd0, 1'b0, 32'h1000_FFFF, 32'h0, "lb_below_data");
    issue(1'b0, 2'd1, 1'b1, 32'h0040_0FFE, 32'h0, "lh_text_top");
    issue(1'b0, 2'd3, 1'b0, 32'h1001_0000, 32'h0, "size_illegal");
    issue(1'b1, 2'd1, 1'b0, 32'h1001_0006, 32'hFFFF_8001, "sh_upper");
    issue(1'b0, 2'd1, 1'b1, 32'h1001_0006, 32'h0, "lh_upper");

    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       a = DBASE + $urandom_range(0, 63);
      else if (r < 8)  a = TBASE + $urandom_range(0, 63);
      else if (r == 8) a = $urandom;
      else             a = DBASE + RSIZE - 4 + $urandom_range(0, 7);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if (sz != 2'd3 && $urandom_range(0, 1) == 1) a = a & ~((32'h1 << sz) - 1);
      w = $urandom;
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, w, "rand");
    end

    // Clear while an sh sits in WRITE, before Memory's negedge commit.
    wait_idle();
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd1; bus.sign_ext = 1'b0;
    bus.addr = 32'h1001_0000; bus.wdata = 32'h0000_BEEF;
    @(posedge clock);
    #1 bus.req = 1'b0;
    @(posedge clock);
    #1;
    chk("sh_in_write", {31'h0, bus.mem_write}, 32'h1);
    clear = 1'b1;
    #1;
    chk("clr_rdata", bus.rdata, 32'h0);
    chk("clr_ready", {31'h0, bus.ready}, 32'h0);
    chk("clr_fault", {31'h0, bus.fault}, 32'h0);
    chk("clr_busy", {31'h0, bus.busy}, 32'h0);
    chk("clr_mem_write", {31'h0, bus.mem_write}, 32'h0);
    chk("clr_mem_address", bus.mem_address, 32'h0);
    chk("clr_mem_wdata", bus.mem_write_data, 32'h0);
    exp_q.delete();
    ref_reset();
    wr_cnt = 0;
    repeat (2) @(negedge clock);
    clear = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'h1001_0000, 32'h0, "lw_after_clear");

    issue(1'b1, 2'd2, 1'b0, 32'h1001_0010, 32'hCAFE_F00D, "sw_data");
    issue(1'b1, 2'd0, 1'b0, 32'h1001_0013, 32'h0000_0077, "sb_top_lane");
    issue(1'b0, 2'd2, 1'b0, 32'h1001_0010, 32'h0, "lw_check");

    wait_idle();
    for (int i = 0; i < 8; i++) begin
      w = {rb(DBASE + 4*i + 3), rb(DBASE + 4*i + 2), rb(DBASE + 4*i + 1), rb(DBASE + 4*i)};
      chk($sformatf("mem_data_%0d", i), data_mem[i], w);
    end
    chk("mem_text_0", text_mem[0], 32'h0022_1820);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
